// File: rtl/game_ctrl_if.sv
// game_ctrl_if: player-facing bundle of the guessing-game controller.
// The master drives the player controls; the slave (game_ctrl) drives the registered status.
interface game_ctrl_if;
  logic       start;
  logic [1:0] diff_sel;
  logic       submit;
  logic [3:0] guess_val;
  logic [7:0] timer;
  logic [2:0] guesses;
  logic [3:0] guess1;
  logic [3:0] guess2;
  logic [3:0] guess3;
  logic [1:0] hint;
  logic [3:0] round;
  logic [1:0] difficulty;
  logic [1:0] WINorLOSE;

  modport master (
    output start, diff_sel, submit, guess_val,
    input  timer, guesses, guess1, guess2, guess3, hint, round, difficulty, WINorLOSE
  );

  modport slave (
    input  start, diff_sel, submit, guess_val,
    output timer, guesses, guess1, guess2, guess3, hint, round, difficulty, WINorLOSE
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: nine-round number-guessing game with per-round second timer, guess history and hints.
// Build macro GAME_AUTOADV_EN: a WIN result auto-advances after RESULT_HOLD timer ticks.
module game_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int RESULT_HOLD = 3
) (
  input logic        clk,
  input logic        reset,
  game_ctrl_if.slave bus
);
  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_WIN, S_LOSE, S_DONE} state_t;

  if (TICK_DIV < 1 || RESULT_HOLD < 1) begin : g_param_check
    $error("game_ctrl: TICK_DIV and RESULT_HOLD must be at least 1");
  end

  state_t        r_state;
  logic [3:0]    r_cnt10;
  logic [3:0]    r_secret;
  logic [TW-1:0] r_tick;
  logic [7:0]    r_timer;
  logic [2:0]    r_guesses;
  logic [3:0]    r_guess1, r_guess2, r_guess3;
  logic [1:0]    r_hint;
  logic [3:0]    r_round;
  logic [1:0]    r_difficulty;
  logic [1:0]    r_wl;

  logic [1:0] w_diff_req, w_load_diff, w_hint;
  logic [7:0] w_load_timer;
  logic [2:0] w_load_guesses;
  logic       w_tick_wrap, w_valid_sub, w_match, w_auto, w_advance;

  assign w_diff_req  = (bus.diff_sel == 2'd0) ? 2'd1 : bus.diff_sel;
  // From IDLE the difficulty is being latched on the same edge, so use the request directly.
  assign w_load_diff = (r_state == S_IDLE) ? w_diff_req : r_difficulty;
  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_valid_sub = bus.submit && (bus.guess_val <= 4'd9);
  assign w_match     = (bus.guess_val == r_secret);
  assign w_hint      = (r_secret < bus.guess_val) ? 2'd0 :
                       (r_secret > bus.guess_val) ? 2'd1 : 2'd2;

  always_comb begin
    w_load_timer   = 8'd90;
    w_load_guesses = 3'd5;
    case (w_load_diff)
      2'd2: begin
        w_load_timer   = 8'd60;
        w_load_guesses = 3'd4;
      end
      2'd3: begin
        w_load_timer   = 8'd30;
        w_load_guesses = 3'd3;
      end
      default: ;
    endcase
  end

`ifdef GAME_AUTOADV_EN
  localparam int HW = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
  logic [HW-1:0] r_hold;

  // Ticks left before auto-advance; reloaded whenever not in WIN.
  always_ff @(posedge clk) begin
    if (reset)                 r_hold <= '0;
    else if (r_state != S_WIN) r_hold <= HW'(RESULT_HOLD - 1);
    else if (w_tick_wrap)      r_hold <= r_hold - 1'b1;
  end

  assign w_auto = (r_state == S_WIN) && w_tick_wrap && (r_hold == '0);
`else
  assign w_auto = 1'b0;
`endif

  assign w_advance = (r_state == S_WIN) && (bus.start || w_auto);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt10      <= 4'd0;
      r_secret     <= 4'd0;
      r_tick       <= '0;
      r_timer      <= 8'd0;
      r_guesses    <= 3'd0;
      r_guess1     <= 4'hF;
      r_guess2     <= 4'hF;
      r_guess3     <= 4'hF;
      r_hint       <= 2'd2;
      r_round      <= 4'd0;
      r_difficulty <= 2'd0;
      r_wl         <= 2'd3;
    end else begin
      r_cnt10 <= (r_cnt10 == 4'd9) ? 4'd0 : r_cnt10 + 4'd1;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_difficulty <= w_diff_req;
            r_round      <= 4'd1;
            r_state      <= S_PLAY;
            r_secret     <= r_cnt10;
            r_tick       <= '0;
            r_timer      <= w_load_timer;
            r_guesses    <= w_load_guesses;
            r_guess1     <= 4'hF;
            r_guess2     <= 4'hF;
            r_guess3     <= 4'hF;
            r_hint       <= 2'd2;
            r_wl         <= 2'd3;
          end
        end
        S_PLAY: begin
          if (w_tick_wrap) begin
            r_tick <= '0;
            if (r_timer != 8'd0) r_timer <= r_timer - 8'd1;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
          if (w_valid_sub) begin
            r_guess3  <= r_guess2;
            r_guess2  <= r_guess1;
            r_guess1  <= bus.guess_val;
            r_guesses <= r_guesses - 3'd1;
            r_hint    <= w_hint;
          end
          // A matching submit beats an expired timer on the same edge.
          if (w_valid_sub && w_match) begin
            r_state <= S_WIN;
            r_wl    <= 2'd1;
            r_tick  <= '0;
          end else if ((w_valid_sub && r_guesses == 3'd1) || r_timer == 8'd0) begin
            r_state <= S_LOSE;
            r_wl    <= 2'd0;
          end
        end
        S_WIN: begin
          r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
          if (w_advance) begin
            if (r_round < 4'd9) begin
              r_round   <= r_round + 4'd1;
              r_state   <= S_PLAY;
              r_secret  <= r_cnt10;
              r_tick    <= '0;
              r_timer   <= w_load_timer;
              r_guesses <= w_load_guesses;
              r_guess1  <= 4'hF;
              r_guess2  <= 4'hF;
              r_guess3  <= 4'hF;
              r_hint    <= 2'd2;
              r_wl      <= 2'd3;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_LOSE, S_DONE: begin
          if (bus.start) begin
            r_state      <= S_IDLE;
            r_timer      <= 8'd0;
            r_guesses    <= 3'd0;
            r_guess1     <= 4'hF;
            r_guess2     <= 4'hF;
            r_guess3     <= 4'hF;
            r_hint       <= 2'd2;
            r_round      <= 4'd0;
            r_difficulty <= 2'd0;
            r_wl         <= 2'd3;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.timer      = r_timer;
  assign bus.guesses    = r_guesses;
  assign bus.guess1     = r_guess1;
  assign bus.guess2     = r_guess2;
  assign bus.guess3     = r_guess3;
  assign bus.hint       = r_hint;
  assign bus.round      = r_round;
  assign bus.difficulty = r_difficulty;
  assign bus.WINorLOSE  = r_wl;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed and randomized checks of game_ctrl against a game-level reference model.
// Works with or without GAME_AUTOADV_EN defined.
`timescale 1ns/1ps
module tb_game_ctrl;
  localparam int TD   = 4;
  localparam int HOLD = 2;
  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_WIN = 2, PH_LOSE = 3, PH_DONE = 4;

  logic clk = 1'b0;
  logic reset;

  game_ctrl_if u_if();

  game_ctrl #(.TICK_DIV(TD), .RESULT_HOLD(HOLD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game phase plus elapsed-cycle counts and a guess history queue.
  int m_phase, m_edges, m_secret, m_diff, m_round, m_t0, m_g0, m_play_cyc, m_win_cyc;
  int m_hist[$];

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_timer();
    int t;
    if (m_phase == PH_IDLE) return 0;
    t = m_t0 - m_play_cyc / TD;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int m_guess_at(input int age);
    if (m_phase == PH_IDLE || age >= m_hist.size()) return 15;
    return m_hist[m_hist.size() - 1 - age];
  endfunction

  function automatic int m_hint();
    int g;
    if (m_phase == PH_IDLE || m_hist.size() == 0) return 2;
    g = m_hist[m_hist.size() - 1];
    if (m_secret < g) return 0;
    if (m_secret > g) return 1;
    return 2;
  endfunction

  function automatic void m_enter_play(input int cnt);
    m_secret   = cnt;
    m_hist.delete();
    m_play_cyc = 0;
    m_win_cyc  = 0;
    m_phase    = PH_PLAY;
    m_t0       = (m_diff == 3) ? 30 : (m_diff == 2) ? 60 : 90;
    m_g0       = (m_diff == 3) ? 3 : (m_diff == 2) ? 4 : 5;
  endfunction

  function automatic void m_reset();
    m_phase  = PH_IDLE;
    m_edges  = 0;
    m_secret = 0;
    m_diff   = 0;
    m_round  = 0;
    m_hist.delete();
    m_play_cyc = 0;
    m_win_cyc  = 0;
  endfunction

  function automatic void m_step(input bit s, input int d, input bit sb, input int g);
    int cnt;
    int tmr;
    bit adv;
    bit ok;
    cnt = m_edges % 10;
    m_edges++;
    ok = sb && (g <= 9);
    case (m_phase)
      PH_IDLE: begin
        if (s) begin
          m_diff  = (d == 0) ? 1 : d;
          m_round = 1;
          m_enter_play(cnt);
        end
      end
      PH_PLAY: begin
        tmr = m_timer();
        m_play_cyc++;
        if (ok) m_hist.push_back(g);
        if (ok && g == m_secret) begin
          m_phase   = PH_WIN;
          m_win_cyc = 0;
        end else if ((ok && m_hist.size() == m_g0) || tmr == 0) begin
          m_phase = PH_LOSE;
        end
      end
      PH_WIN: begin
        adv = s;
`ifdef GAME_AUTOADV_EN
        if (m_win_cyc + 1 == HOLD * TD) adv = 1'b1;
`endif
        m_win_cyc++;
        if (adv) begin
          if (m_round < 9) begin
            m_round++;
            m_enter_play(cnt);
          end else begin
            m_phase = PH_DONE;
          end
        end
      end
      default: begin
        if (s) begin
          m_phase = PH_IDLE;
          m_round = 0;
          m_diff  = 0;
          m_hist.delete();
        end
      end
    endcase
  endfunction

  task automatic compare_all(input string tag);
    int exp_wl;
    int exp_gs;
    exp_wl = (m_phase == PH_WIN || m_phase == PH_DONE) ? 1 : (m_phase == PH_LOSE) ? 0 : 3;
    exp_gs = (m_phase == PH_IDLE) ? 0 : m_g0 - m_hist.size();
    check_val({tag, ".timer"},      int'(u_if.timer),      m_timer());
    check_val({tag, ".guesses"},    int'(u_if.guesses),    exp_gs);
    check_val({tag, ".guess1"},     int'(u_if.guess1),     m_guess_at(0));
    check_val({tag, ".guess2"},     int'(u_if.guess2),     m_guess_at(1));
    check_val({tag, ".guess3"},     int'(u_if.guess3),     m_guess_at(2));
    check_val({tag, ".hint"},       int'(u_if.hint),       m_hint());
    check_val({tag, ".round"},      int'(u_if.round),      m_round);
    check_val({tag, ".difficulty"}, int'(u_if.difficulty), m_diff);
    check_val({tag, ".WINorLOSE"},  int'(u_if.WINorLOSE),  exp_wl);
  endtask

  task automatic step(input string tag, input bit s, input int d, input bit sb, input int g);
    u_if.start     = s;
    u_if.diff_sel  = 2'(d);
    u_if.submit    = sb;
    u_if.guess_val = 4'(g);
    @(posedge clk);
    m_step(s, d, sb, g);
    @(negedge clk);
    u_if.start  = 1'b0;
    u_if.submit = 1'b0;
    compare_all(tag);
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    u_if.start  = 1'b0;
    u_if.submit = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    compare_all("reset");
  endtask

  initial begin
    int wrong;
    u_if.start     = 1'b0;
    u_if.diff_sel  = 2'd0;
    u_if.submit    = 1'b0;
    u_if.guess_val = 4'd0;
    reset          = 1'b1;

    do_reset();
    check_val("rst.WINorLOSE", int'(u_if.WINorLOSE), 3);
    check_val("rst.guess1", int'(u_if.guess1), 15);

    // Start at difficulty 2
    step("start_d2", 1'b1, 2, 1'b0, 0);
    check_val("d2.round", int'(u_if.round), 1);
    check_val("d2.difficulty", int'(u_if.difficulty), 2);
    check_val("d2.timer", int'(u_if.timer), 60);
    check_val("d2.guesses", int'(u_if.guesses), 4);
    check_val("d2.WINorLOSE", int'(u_if.WINorLOSE), 3);

    // Secret 5: start on the sixth edge after reset; guesses 7 then 2
    do_reset();
    idle_steps("pre5", 5);
    step("start5", 1'b1, 2, 1'b0, 0);
    step("sub7", 1'b0, 0, 1'b1, 7);
    check_val("s5.hint_after7", int'(u_if.hint), 0);
    step("sub2", 1'b0, 0, 1'b1, 2);
    check_val("s5.hint_after2", int'(u_if.hint), 1);
    check_val("s5.guess1", int'(u_if.guess1), 2);
    check_val("s5.guess2", int'(u_if.guess2), 7);
    check_val("s5.guess3", int'(u_if.guess3), 15);
    check_val("s5.guesses", int'(u_if.guesses), 2);

    // Difficulty 3 timeout
    do_reset();
    step("start_d3", 1'b1, 3, 1'b0, 0);
    idle_steps("tmo", 119);
    check_val("tmo.timer_119", int'(u_if.timer), 1);
    step("tmo120", 1'b0, 0, 1'b0, 0);
    check_val("tmo.timer_zero", int'(u_if.timer), 0);
    check_val("tmo.still_playing", int'(u_if.WINorLOSE), 3);
    step("tmo121", 1'b0, 0, 1'b0, 0);
    check_val("tmo.lose", int'(u_if.WINorLOSE), 0);
    step("tmo_start", 1'b1, 0, 1'b0, 0);
    check_val("tmo.idle_round", int'(u_if.round), 0);
    check_val("tmo.idle_wl", int'(u_if.WINorLOSE), 3);

    // Three wrong guesses at difficulty 3, then an out-of-range submit
    do_reset();
    idle_steps("pre_l", 3);
    step("start_l", 1'b1, 3, 1'b0, 0);
    for (int k = 1; k <= 3; k++) begin
      wrong = (m_secret + k) % 10;
      step("wrong", 1'b0, 0, 1'b1, wrong);
    end
    check_val("lose.wl", int'(u_if.WINorLOSE), 0);
    check_val("lose.guesses", int'(u_if.guesses), 0);
    step("sub12", 1'b0, 0, 1'b1, 12);
    check_val("lose.sub12_guesses", int'(u_if.guesses), 0);
    check_val("lose.sub12_guess1", int'(u_if.guess1), wrong);

    // Win nine rounds, DONE, back to IDLE
    do_reset();
    step("start_w", 1'b1, 1, 1'b0, 0);
    for (int r = 1; r <= 9; r++) begin
      idle_steps("wait_w", r % 3);
      step("win_sub", 1'b0, 0, 1'b1, m_secret);
      check_val("win.wl", int'(u_if.WINorLOSE), 1);
      check_val("win.round", int'(u_if.round), r);
      step("win_start", 1'b1, 0, 1'b0, 0);
    end
    check_val("done.wl", int'(u_if.WINorLOSE), 1);
    check_val("done.round", int'(u_if.round), 9);
    step("done_start", 1'b1, 0, 1'b0, 0);
    check_val("done.idle_round", int'(u_if.round), 0);
    check_val("done.idle_wl", int'(u_if.WINorLOSE), 3);

    // Held WIN result with no start
    do_reset();
    step("start_a", 1'b1, 2, 1'b0, 0);
    step("win_a", 1'b0, 0, 1'b1, m_secret);
    idle_steps("hold", 8);
`ifdef GAME_AUTOADV_EN
    check_val("hold.round", int'(u_if.round), 2);
`else
    check_val("hold.round", int'(u_if.round), 1);
`endif

    // Reset mid-game and mid-tick
    step("start_m", 1'b1, 1, 1'b0, 0);
    idle_steps("mid", 6);
    do_reset();

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        bit s, sb;
        int d, g;
        s  = ($urandom_range(0, 15) == 0);
        sb = ($urandom_range(0, 3) == 0);
        d  = $urandom_range(0, 3);
        g  = ($urandom_range(0, 2) == 0) ? m_secret : $urandom_range(0, 15);
        step("rnd", s, d, sb, g);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
